// File: rtl/inbuf_loader.sv
// rtl/inbuf_loader.sv - stream-to-input-buffer loader with word/half/byte unpacking
//
// Accepts 32-bit stream beats and writes them into an input buffer,
// one write per cycle, splitting each beat into 1, 2 or 4 zero-extended
// sub-words depending on the mode latched at start.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle load request (honoured only in IDLE)
//   current_state        controller state, selects load mode at start
//   poolingen_op         pooling enable, selects HALF mode at start
//   base_addr            first buffer write address
//   wr_len               number of buffer writes (0 = zero-length load)
//   s_valid/s_data       incoming stream beat
//   s_ready              beat accepted this cycle when s_valid is high
//   we/a/d               registered buffer write port
//   busy                 high in LOAD and DRAIN
//   done                 one-cycle completion pulse

`timescale 1ns/1ps

module inbuf_loader #(
    parameter int InBuAddrWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               current_state,
    input  logic                     poolingen_op,
    input  logic [InBuAddrWidth-1:0] base_addr,
    input  logic [InBuAddrWidth:0]   wr_len,
    input  logic                     s_valid,
    input  logic [31:0]              s_data,
    output logic                     s_ready,
    output logic                     we,
    output logic [InBuAddrWidth-1:0] a,
    output logic [31:0]              d,
    output logic                     busy,
    output logic                     done
);

    localparam int W = InBuAddrWidth;
    localparam logic [W-1:0] ADDR_ONE = 1;
    localparam logic [W:0]   CNT_ONE  = 1;
    localparam logic [W:0]   CNT_ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {M_WORD, M_HALF, M_BYTE} mode_t;

    state_t      state_q;
    mode_t       mode_q;
    logic [W-1:0] addr_q;
    logic [W:0]   cnt_q;
    logic [31:0]  beat_q;
    logic         full_q;
    logic [1:0]   sub_q;
    logic         we_q;
    logic [W-1:0] a_q;
    logic [31:0]  d_q;

    logic        last_sub;
    logic        final_wr;
    logic        ready_c;
    logic        accept;
    logic        issue;
    logic [31:0] src_word;
    logic [1:0]  src_sub;
    logic [31:0] wr_data;

    function automatic logic [31:0] pick_sub(input mode_t m, input logic [31:0] w,
                                             input logic [1:0] k);
        case (m)
            M_WORD:  pick_sub = w;
            M_HALF:  pick_sub = {16'h0, (k[0] ? w[31:16] : w[15:0])};
            default: pick_sub = {24'h0, w[8*k +: 8]};
        endcase
    endfunction

    always_comb begin
        last_sub = (mode_q == M_WORD) ||
                   ((mode_q == M_HALF) && (sub_q == 2'd1)) ||
                   ((mode_q == M_BYTE) && (sub_q == 2'd3));
        final_wr = (cnt_q == CNT_ONE);
        // A held beat frees the register only on its last sub-word, and never
        // on the final write: leftover sub-words of the last beat are dropped.
        ready_c  = (state_q == S_LOAD) && (!full_q || (last_sub && !final_wr));
        accept   = ready_c && s_valid;
        // An empty holding register lets an arriving beat issue its first
        // sub-word immediately, keeping WORD mode at one beat per cycle.
        issue    = (state_q == S_LOAD) && (full_q || accept);
        src_word = full_q ? beat_q : s_data;
        src_sub  = full_q ? sub_q : 2'd0;
        wr_data  = pick_sub(mode_q, src_word, src_sub);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_WORD;
            addr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            full_q  <= 1'b0;
            sub_q   <= 2'd0;
            we_q    <= 1'b0;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (current_state == 4'd0) begin
                            mode_q <= M_WORD;
                        end else if (poolingen_op || (current_state == 4'd1)) begin
                            mode_q <= M_HALF;
                        end else begin
                            mode_q <= M_BYTE;
                        end
                        addr_q  <= base_addr;
                        cnt_q   <= wr_len;
                        full_q  <= 1'b0;
                        sub_q   <= 2'd0;
                        state_q <= (wr_len == CNT_ZERO) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (issue) begin
                        we_q   <= 1'b1;
                        a_q    <= addr_q;
                        d_q    <= wr_data;
                        addr_q <= addr_q + ADDR_ONE;
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (final_wr) begin
                            full_q  <= 1'b0;
                            state_q <= S_DRAIN;
                        end else if (full_q) begin
                            if (last_sub) begin
                                // Refill from a beat accepted in the same cycle.
                                full_q <= accept;
                                beat_q <= accept ? s_data : beat_q;
                                sub_q  <= 2'd0;
                            end else begin
                                sub_q <= sub_q + 2'd1;
                            end
                        end else if (mode_q != M_WORD) begin
                            full_q <= 1'b1;
                            beat_q <= s_data;
                            sub_q  <= 2'd1;
                        end
                    end
                end
                S_DRAIN: state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_ready = ready_c;
    assign we      = we_q;
    assign a       = a_q;
    assign d       = d_q;
    assign busy    = (state_q == S_LOAD) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);

endmodule

// File: doc/inbuf_loader.md
INBUF_LOADER -- requirements
Module: inbuf_loader

Interface
REQ-001 SHALL have parameter InBuAddrWidth, default 8, the width of the input-buffer write address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a load; ignored unless the block is IDLE.
REQ-005 SHALL have port current_state, input, 4 bits: the controller state, sampled at start.
REQ-006 SHALL have port poolingen_op, input, 1 bit: the pooling enable, sampled at start.
REQ-007 SHALL have port base_addr, input, InBuAddrWidth bits: the first write address, sampled at start.
REQ-008 SHALL have port wr_len, input, InBuAddrWidth+1 bits: the number of buffer writes, sampled at start; legal range is 1..2^InBuAddrWidth.
REQ-009 SHALL have port s_valid, input, 1 bit: the stream beat is valid.
REQ-010 SHALL have port s_data, input, 32 bits: the stream beat payload.
REQ-011 SHALL have port s_ready, output, 1 bit: the block accepts the beat this cycle.
REQ-012 SHALL have port we, output, 1 bit: the buffer write enable.
REQ-013 SHALL have port a, output, InBuAddrWidth bits: the buffer write address.
REQ-014 SHALL have port d, output, 32 bits: the buffer write data.
REQ-015 SHALL have port busy, output, 1 bit: high in the LOAD and DRAIN states.
REQ-016 SHALL have port done, output, 1 bit: a one-cycle pulse when the load completes.

Function
REQ-017 SHALL latch the load mode at start as follows:
- WORD when current_state==0.
- else HALF when poolingen_op==1 or current_state==1.
- else BYTE.
REQ-018 SHALL implement the states IDLE, LOAD, DRAIN and DONE:
- IDLE->LOAD on start.
- LOAD->DRAIN when the last write is issued.
- DRAIN->DONE after one cycle.
- DONE->IDLE after one cycle.
REQ-019 SHALL hold a one-beat holding register (beat) and a sub-index (0..3).
REQ-020 SHALL assert s_ready only in LOAD, and only when the holding register is empty or its last sub-word is being issued this cycle.
REQ-021 SHALL accept a beat on a cycle where s_valid and s_ready are both high; a beat is never dropped and never accepted twice.
REQ-022 SHALL, in WORD mode, perform one write per beat with d=s_data.
REQ-023 SHALL, in HALF mode, perform two writes per beat:
- first write: d={16'h0, beat[15:0]};
- second write: d={16'h0, beat[31:16]}.
REQ-024 SHALL, in BYTE mode, perform four writes per beat, for k=0..3 in order: d={24'h0, beat[8k+7:8k]}.
REQ-025 SHALL register we, a and d, so that the write for an accepted WORD beat appears on the cycle after acceptance.
REQ-026 SHALL produce back-to-back writes, one per cycle, while data is available, so that sustained WORD throughput is one beat per cycle.
REQ-027 SHALL issue the n-th write (n=0..wr_len-1) at a=base_addr+n modulo 2^InBuAddrWidth, with wrap-around and no error.
REQ-028 SHALL count writes, not beats, and stop after exactly wr_len writes.
REQ-029 SHALL discard the unused sub-words of the final beat when wr_len is not a multiple of the sub-word count, with no further s_ready.
REQ-030 SHALL hold we low and a and d stable in every cycle without a write, including stalls from s_valid being low.
REQ-031 SHALL pulse done one cycle after the final write, that is, in the DONE state.
REQ-032 SHALL ignore start while busy or done is high, with no restart and no re-sampling.
REQ-033 SHALL treat wr_len==0 at start as a zero-length load: IDLE->DONE directly, done pulse, no writes, s_ready never high.

Reset
REQ-034 SHALL, on rst high at any time, asynchronously force:
- the state to IDLE;
- s_ready, we, busy and done to 0;
- a, d, the counters and the holding register to 0.
REQ-035 SHALL, when reset is asserted mid-load, abandon the load without completing the in-flight write and without a done pulse.
REQ-036 SHALL, after rst deasserts, accept start on the first clock edge.

Verification
REQ-037 SHALL cover WORD mode: current_state=0, base_addr=0, wr_len=4, beats 0x11223344 to 0x44556677 with s_valid held high -> writes at a=0,1,2,3 on consecutive cycles with d equal to each beat, and done one cycle after the a=3 write.
REQ-038 SHALL cover HALF mode: current_state=1, base_addr=0x10, wr_len=3, beats 0xAAAA5555 and 0xCCCC3333 -> writes a=0x10 d=0x5555, a=0x11 d=0xAAAA, a=0x12 d=0x3333; then 0xCCCC is discarded and s_ready stays low after the second beat.
REQ-039 SHALL cover BYTE mode: current_state=2, poolingen_op=0, base_addr=0xFE, wr_len=4, beat 0x04030201 -> writes a=0xFE,0xFF,0x00,0x01 (wrap) with d=0x01,0x02,0x03,0x04, and s_ready low during the last three.
REQ-040 SHALL cover stalls: WORD mode with wr_len=2, s_valid low for 3 cycles between beats -> we low and a stable during the gap, exactly 2 writes, and one done pulse.
REQ-041 SHALL cover reset mid-operation: rst pulsed after 2 of 8 writes -> all outputs 0 immediately, no done; then a new start with wr_len=1 completes normally.
REQ-042 SHALL cover start while busy: a second start during LOAD -> ignored, with the write count and address sequence of the first load unchanged.
